// File: rtl/wdt_resp_ctrl_if.sv
// Handshake/control bundle between the WDT counter/regfile side and the
// watchdog response controller.
interface wdt_resp_ctrl_if #(
   parameter int CNT_WIDTH     = 32,
   parameter int RST_LEN_WIDTH = 8,
   parameter int RST_CNT_WIDTH = 4
);
   logic                     clk_en;
   logic                     pause;
   logic [CNT_WIDTH-1:0]     cnt_val;
   logic                     restart;
   logic                     eoi_en;
   logic                     warn_clr;
   logic                     cause_clr;
   logic                     resp_mod;
   logic                     win_en;
   logic [CNT_WIDTH-1:0]     win_lo;
   logic [CNT_WIDTH-1:0]     warn_thresh;
   logic [RST_LEN_WIDTH-1:0] rst_pulse_len;
   logic                     wdt_int;
   logic                     warn_int;
   logic                     sys_rst;
   logic [1:0]               rst_cause;
   logic [RST_CNT_WIDTH-1:0] rst_count;

   modport master (
      output clk_en, pause, cnt_val, restart, eoi_en, warn_clr, cause_clr,
             resp_mod, win_en, win_lo, warn_thresh, rst_pulse_len,
      input  wdt_int, warn_int, sys_rst, rst_cause, rst_count
   );

   modport slave (
      input  clk_en, pause, cnt_val, restart, eoi_en, warn_clr, cause_clr,
             resp_mod, win_en, win_lo, warn_thresh, rst_pulse_len,
      output wdt_int, warn_int, sys_rst, rst_cause, rst_count
   );
endinterface

// File: rtl/wdt_resp_ctrl.sv
// Watchdog response controller: turns counter events into warning/timeout
// interrupts and a fixed-length system-reset pulse with sticky cause flags.
module wdt_resp_ctrl #(
   parameter int CNT_WIDTH     = 32,
   parameter int RST_LEN_WIDTH = 8,
   parameter int RST_CNT_WIDTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   wdt_resp_ctrl_if.slave bus
);
   typedef enum logic [1:0] {RUN = 2'd0, INT = 2'd1, RST = 2'd2} state_t;

   state_t                   state, state_nxt;
   logic [RST_LEN_WIDTH-1:0] pcnt, len_m1;
   logic                     tmo, warn_hit, win_viol;
   logic                     set_tmo, set_viol, enter_rst, act;
   logic                     wdt_q, warn_q, rst_q;
   logic [1:0]               cause_q;
   logic [RST_CNT_WIDTH-1:0] count_q;

   assign tmo      = (bus.cnt_val == '0) & bus.clk_en & ~bus.pause;
   assign warn_hit = (bus.cnt_val == bus.warn_thresh) & (bus.warn_thresh != '0)
                   & bus.clk_en & ~bus.pause;
   assign win_viol = bus.win_en & bus.restart & (bus.cnt_val > bus.win_lo);
   assign len_m1   = (bus.rst_pulse_len == '0) ? '0 : bus.rst_pulse_len - 1'b1;

   always_comb begin
      state_nxt = state;
      set_tmo   = 1'b0;
      set_viol  = 1'b0;
      case (state)
         RUN: begin
            if (win_viol) begin
               state_nxt = RST;
               set_viol  = 1'b1;
            end else if (tmo && bus.resp_mod) begin
               state_nxt = INT;
            end else if (tmo) begin
               state_nxt = RST;
               set_tmo   = 1'b1;
            end
         end
         INT: begin
            // clear beats a same-cycle second timeout
            if (win_viol) begin
               state_nxt = RST;
               set_viol  = 1'b1;
            end else if (bus.restart || bus.eoi_en) begin
               state_nxt = RUN;
            end else if (tmo) begin
               state_nxt = RST;
               set_tmo   = 1'b1;
            end
         end
         RST: begin
            if (pcnt == len_m1) state_nxt = RUN;
         end
         default: state_nxt = RUN;
      endcase
   end

   assign act       = (state != RST);
   assign enter_rst = act & (state_nxt == RST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RUN;
         pcnt  <= '0;
         wdt_q <= 1'b0;
         rst_q <= 1'b0;
      end else begin
         state <= state_nxt;
         wdt_q <= (state_nxt == INT);
         rst_q <= (state_nxt == RST);
         pcnt  <= (state == RST && state_nxt == RST) ? pcnt + 1'b1 : '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         warn_q <= 1'b0;
      end else if (act) begin
         if (enter_rst || bus.warn_clr || bus.restart) warn_q <= 1'b0;
         else if (state == RUN && warn_hit)              warn_q <= 1'b1;
      end
   end

   // a same-cycle cause_clr and set leave the new cause and a count of 1
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cause_q <= 2'b00;
         count_q <= '0;
      end else if (act) begin
         if (bus.cause_clr) begin
            cause_q <= {set_viol, set_tmo};
            count_q <= enter_rst ? RST_CNT_WIDTH'(1) : '0;
         end else begin
            cause_q <= cause_q | {set_viol, set_tmo};
            if (enter_rst && count_q != '1) count_q <= count_q + 1'b1;
         end
      end
   end

   assign bus.wdt_int   = wdt_q;
   assign bus.warn_int  = warn_q;
   assign bus.sys_rst   = rst_q;
   assign bus.rst_cause = cause_q;
   assign bus.rst_count = count_q;
endmodule

// File: tb/tb_wdt_resp_ctrl.sv
// Scoreboard bench: a behavioural model pushes expected outputs each cycle,
// which are popped and compared after the DUT clock edge.
module tb_wdt_resp_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;

   wdt_resp_ctrl_if bus ();

   wdt_resp_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       wdt;
      logic       warn;
      logic       sys;
      logic [1:0] cause;
      logic [3:0] cnt;
   } exp_t;

   exp_t sb[$];
   int   n_chk = 0;
   int   n_err = 0;

   // model state: 0 = RUN, 1 = INT, 2 = RST
   int         m_state;
   int         m_elapsed;
   logic       m_warn;
   logic [1:0] m_cause;
   logic [3:0] m_cnt;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_elapsed = 0; m_warn = 1'b0; m_cause = 2'b00; m_cnt = 4'd0;
   endtask

   task automatic push_exp();
      exp_t e;
      e.wdt = (m_state == 1); e.warn = m_warn; e.sys = (m_state == 2);
      e.cause = m_cause; e.cnt = m_cnt;
      sb.push_back(e);
   endtask

   task automatic compare_out(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'd1, 32'd0);
         return;
      end
      e = sb.pop_front();
      chk({tag, "_wdt_int"},   32'(bus.wdt_int),   32'(e.wdt));
      chk({tag, "_warn_int"},  32'(bus.warn_int),  32'(e.warn));
      chk({tag, "_sys_rst"},   32'(bus.sys_rst),   32'(e.sys));
      chk({tag, "_rst_cause"}, 32'(bus.rst_cause), 32'(e.cause));
      chk({tag, "_rst_count"}, 32'(bus.rst_count), 32'(e.cnt));
   endtask

   task automatic model_step();
      logic tmo, whit, viol, st, sv;
      int   nst, len;
      tmo  = (bus.cnt_val == 0) && bus.clk_en && !bus.pause;
      whit = (bus.cnt_val == bus.warn_thresh) && (bus.warn_thresh != 0) && bus.clk_en && !bus.pause;
      viol = bus.win_en && bus.restart && (bus.cnt_val > bus.win_lo);
      nst = m_state; st = 1'b0; sv = 1'b0;
      if (m_state == 0) begin
         if (viol) begin nst = 2; sv = 1'b1; end
         else if (tmo && bus.resp_mod) nst = 1;
         else if (tmo) begin nst = 2; st = 1'b1; end
      end else if (m_state == 1) begin
         if (viol) begin nst = 2; sv = 1'b1; end
         else if (bus.restart || bus.eoi_en) nst = 0;
         else if (tmo) begin nst = 2; st = 1'b1; end
      end else begin
         len = (bus.rst_pulse_len == 0) ? 1 : int'(bus.rst_pulse_len);
         if (m_elapsed + 1 >= len) nst = 0;
      end
      if (m_state != 2) begin
         if (nst == 2 || bus.warn_clr || bus.restart) m_warn = 1'b0;
         else if (m_state == 0 && whit) m_warn = 1'b1;
         if (bus.cause_clr) begin m_cause = 2'b00; m_cnt = 4'd0; end
         m_cause = m_cause | {sv, st};
         if (nst == 2 && m_cnt != 4'hF) m_cnt = m_cnt + 4'd1;
      end
      m_elapsed = (m_state == 2 && nst == 2) ? m_elapsed + 1 : 0;
      m_state = nst;
   endtask

   // inputs are already set; model the edge, let the DUT take it, compare
   task automatic step(input string tag);
      model_step();
      push_exp();
      @(posedge clk);
      #1;
      compare_out(tag);
      bus.restart = 1'b0; bus.eoi_en = 1'b0; bus.warn_clr = 1'b0; bus.cause_clr = 1'b0;
   endtask

   task automatic idle(input int n, input string tag);
      bus.cnt_val = 1000;
      for (int i = 0; i < n; i++) step(tag);
   endtask

   initial begin
      bus.clk_en = 1'b1; bus.pause = 1'b0; bus.cnt_val = 1000;
      bus.restart = 1'b0; bus.eoi_en = 1'b0; bus.warn_clr = 1'b0; bus.cause_clr = 1'b0;
      bus.resp_mod = 1'b0; bus.win_en = 1'b0; bus.win_lo = 100;
      bus.warn_thresh = 0; bus.rst_pulse_len = 4;
      model_reset();
      #2;
      push_exp(); compare_out("reset");
      #11 rst_n = 1'b1;
      @(posedge clk); #1;

      // timeout with immediate reset, 4-cycle pulse
      bus.cnt_val = 0; step("tmo_rst");
      idle(6, "tmo_pulse");

      // interrupt-first: clear wins over a second timeout
      bus.resp_mod = 1'b1;
      bus.cnt_val = 0; step("int_first");
      idle(2, "int_hold");
      bus.cnt_val = 0; bus.eoi_en = 1'b1; step("eoi_vs_tmo");
      idle(2, "after_eoi");
      bus.cnt_val = 0; step("int_again");
      idle(2, "int_hold2");
      bus.cnt_val = 0; step("second_tmo");
      idle(5, "second_pulse");

      // window violation and legal boundary restart
      bus.win_en = 1'b1;
      bus.cnt_val = 101; bus.restart = 1'b1; step("win_viol");
      idle(5, "viol_pulse");
      bus.cnt_val = 100; bus.restart = 1'b1; step("win_ok");
      idle(1, "win_ok_idle");
      bus.win_en = 1'b0;

      // early warning
      bus.resp_mod = 1'b0;
      bus.warn_thresh = 50;
      bus.cnt_val = 50; bus.pause = 1'b1; step("warn_paused");
      bus.pause = 1'b0; step("warn_set");
      bus.cnt_val = 49; step("warn_hold");
      bus.warn_clr = 1'b1; step("warn_clr");
      bus.warn_thresh = 0; bus.resp_mod = 1'b1;
      bus.cnt_val = 0; step("warn_dis");
      bus.cnt_val = 1000; bus.eoi_en = 1'b1; step("warn_dis_eoi");
      bus.resp_mod = 1'b0;

      // zero length pulse and counter saturation
      bus.rst_pulse_len = 0;
      for (int i = 0; i < 17; i++) begin
         bus.cnt_val = 0; step("sat_tmo");
         idle(1, "sat_idle");
      end
      bus.cause_clr = 1'b1; step("cause_clr");
      bus.cause_clr = 1'b1; bus.cnt_val = 0; step("clr_vs_set");
      idle(2, "clr_vs_set_idle");

      // async reset mid-pulse
      bus.rst_pulse_len = 8;
      bus.cnt_val = 0; step("long_tmo");
      idle(1, "long_pulse");
      #3 rst_n = 1'b0;
      model_reset();
      #1; push_exp(); compare_out("async_rst");
      #3 rst_n = 1'b1;
      idle(10, "post_rst");

      // randomized traffic with a fixed pulse length
      bus.rst_pulse_len = 3; bus.warn_thresh = 50; bus.win_lo = 100;
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 7))
            0, 1:    bus.cnt_val = 0;
            2:       bus.cnt_val = 50;
            3:       bus.cnt_val = 100;
            4:       bus.cnt_val = 101;
            default: bus.cnt_val = $urandom_range(0, 200);
         endcase
         bus.clk_en    = ($urandom_range(0, 3) != 0);
         bus.pause     = ($urandom_range(0, 7) == 0);
         bus.restart   = ($urandom_range(0, 5) == 0);
         bus.eoi_en    = ($urandom_range(0, 5) == 0);
         bus.warn_clr  = ($urandom_range(0, 7) == 0);
         bus.cause_clr = ($urandom_range(0, 9) == 0);
         bus.resp_mod  = ($urandom_range(0, 1) == 0);
         bus.win_en    = ($urandom_range(0, 1) == 0);
         step("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
